// File: rtl/rate_ticker_pkg.sv
// -----------------------------------------------------------------------------
// rate_ticker_pkg
//
// Shared definitions for the rate_ticker block:
//   - state_e        : FSM state encoding (IDLE / RUN)
//   - MODE_*         : values of the i_mode input
//   - rate_limit()   : elaboration-time helper that returns the terminal count
//                      of rate index k, i.e. 2**(shift_base+k) - 1
// -----------------------------------------------------------------------------
package rate_ticker_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Terminal count for rate index k. The exponent is clamped to the counter
    // width so that a mis-parametrised instance still yields an all-ones limit
    // instead of wrapping to a tiny value.
    function automatic logic [63:0] rate_limit(input int nb_count,
                                               input int shift_base,
                                               input int k);
        int exp_bits;
        exp_bits = shift_base + k;
        if (exp_bits > nb_count) begin
            exp_bits = nb_count;
        end
        return (64'd1 << exp_bits) - 64'd1;
    endfunction

endpackage : rate_ticker_pkg

// File: rtl/rate_limit_table.sv
// -----------------------------------------------------------------------------
// rate_limit_table
//
// Combinational selector-to-limit lookup. Every selector code gets a slot;
// codes at or above N_RATES are clamped onto the slowest rate (N_RATES-1).
//
// Ports:
//   sel_i   [NB_SEL-1:0]   rate index
//   limit_o [NB_COUNT-1:0] terminal count for that rate
// -----------------------------------------------------------------------------
module rate_limit_table #(
    parameter int NB_COUNT   = 32,
    parameter int N_RATES    = 4,
    parameter int NB_SEL     = 2,
    parameter int SHIFT_BASE = 22
) (
    input  logic [NB_SEL-1:0]   sel_i,
    output logic [NB_COUNT-1:0] limit_o
);
    import rate_ticker_pkg::*;

    localparam int N_SLOTS = 2 ** NB_SEL;

    logic [NB_COUNT-1:0] lim_tab [N_SLOTS];

    // All limits are elaboration-time constants; the table collapses to a
    // small constant mux after synthesis.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            localparam int K = (gi < N_RATES) ? gi : (N_RATES - 1);
            assign lim_tab[gi] = NB_COUNT'(rate_limit(NB_COUNT, SHIFT_BASE, K));
        end
    endgenerate

    assign limit_o = lim_tab[sel_i];

endmodule : rate_limit_table

// File: rtl/rate_ticker.sv
// -----------------------------------------------------------------------------
// rate_ticker
//
// Run-time selectable power-of-two clock divider producing a one-cycle tick
// (used downstream as a shift enable). Periodic or one-shot operation, start
// trigger, synchronous clear, glitch-free rate switching and a wrapping tick
// event counter.
//
// Ports:
//   clk            in   system clock, rising edge
//   i_ck_reset     in   asynchronous active-low reset
//   i_count_enable in   counting enable; low pauses without losing state
//   i_count_sel    in   rate index (values >= N_RATES select the slowest rate)
//   i_mode         in   0 = periodic, 1 = one-shot
//   i_start        in   one-shot trigger, honoured only while idle
//   i_clear        in   synchronous clear back to idle
//   o_tick         out  one-cycle pulse at each terminal count
//   o_busy         out  high while running
//   o_tick_count   out  ticks since reset/clear, wraps
// -----------------------------------------------------------------------------
module rate_ticker #(
    parameter int NB_COUNT   = 32,
    parameter int N_RATES    = 4,
    parameter int NB_SEL     = 2,
    parameter int SHIFT_BASE = 22,
    parameter int NB_TICKS   = 8
) (
    input  logic                clk,
    input  logic                i_ck_reset,
    input  logic                i_count_enable,
    input  logic [NB_SEL-1:0]   i_count_sel,
    input  logic                i_mode,
    input  logic                i_start,
    input  logic                i_clear,
    output logic                o_tick,
    output logic                o_busy,
    output logic [NB_TICKS-1:0] o_tick_count
);
    import rate_ticker_pkg::*;

    // Value held by the limit register while reset is asserted. Once out of
    // reset the idle state reloads it from the selector on every edge.
    localparam logic [NB_COUNT-1:0] RESET_LIMIT =
        NB_COUNT'(rate_limit(NB_COUNT, SHIFT_BASE, 0));

    state_e              state_q, state_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic [NB_COUNT-1:0] limit_q, limit_d;
    logic                tick_q, tick_d;
    logic [NB_TICKS-1:0] tick_cnt_q, tick_cnt_d;

    logic [NB_COUNT-1:0] sel_limit;
    logic                terminal;
    logic                start_run;

    rate_limit_table #(
        .NB_COUNT   (NB_COUNT),
        .N_RATES    (N_RATES),
        .NB_SEL     (NB_SEL),
        .SHIFT_BASE (SHIFT_BASE)
    ) u_limit_table (
        .sel_i   (i_count_sel),
        .limit_o (sel_limit)
    );

    // Terminal count compares against the latched limit, never the live
    // selector, so a rate change mid-period cannot shorten or stretch it.
    assign terminal  = (state_q == ST_RUN) && i_count_enable && (count_q == limit_q);
    assign start_run = ((i_mode == MODE_PERIODIC) && i_count_enable) || i_start;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_ck_reset) begin
        if (!i_ck_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_run) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Mode is sampled only at the terminal count.
                    if (terminal && (i_mode == MODE_ONESHOT)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: datapath / output next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        limit_d    = limit_q;
        tick_d     = 1'b0;
        tick_cnt_d = tick_cnt_q;

        if (i_clear) begin
            // Clear wins over a coincident terminal count: no tick, count zeroed.
            count_d    = '0;
            limit_d    = sel_limit;
            tick_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            // The IDLE->RUN edge itself is not a counting edge.
            count_d = '0;
            limit_d = sel_limit;
        end else if (i_count_enable) begin
            if (terminal) begin
                count_d    = '0;
                limit_d    = sel_limit;
                tick_d     = 1'b1;
                tick_cnt_d = tick_cnt_q + NB_TICKS'(1);
            end else begin
                count_d = count_q + NB_COUNT'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_ck_reset) begin
        if (!i_ck_reset) begin
            count_q    <= '0;
            limit_q    <= RESET_LIMIT;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            limit_q    <= limit_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all taken straight from registers)
    // -------------------------------------------------------------------------
    always_comb begin
        o_busy       = (state_q == ST_RUN);
        o_tick       = tick_q;
        o_tick_count = tick_cnt_q;
    end

endmodule : rate_ticker
